// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern-search sequencer.
package pattern_scan_pkg;

    localparam int NBYTES      = 32;
    localparam int PAT_ADDR    = 32;
    localparam int RES_ADDR    = 33;
    localparam int PAT_W       = 5;
    localparam int SCAN_CYCLES = NBYTES;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PAT,
        SCAN,
        DRAIN,
        WR_CTB,
        WR_CTO,
        WR_CTS,
        DONE
    } scan_state_t;

endpackage

// File: rtl/pat_win_cnt.sv
// Counts 5-bit pattern hits in a {prev,cur} byte pair: the in-byte windows of cur
// and the eight windows that start inside prev (bit 15 is first in string order).
module pat_win_cnt
    import pattern_scan_pkg::*;
(
    input  logic [15:0]      win,
    input  logic [PAT_W-1:0] pat,
    input  logic             mode,
    output logic [2:0]       in_cnt,
    output logic [3:0]       x_cnt
);

    always_comb begin
        in_cnt = '0;
        x_cnt  = '0;
        for (int k = 0; k < 4; k++) begin
            if (win[k +: PAT_W] == pat) in_cnt = in_cnt + 3'd1;
        end
        // mode=0 for the first byte of the string, which has no predecessor
        if (mode) begin
            for (int k = 0; k < 8; k++) begin
                if (win[11-k +: PAT_W] == pat) x_cnt = x_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencer that owns the data-memory port while busy: loads the pattern, streams the
// search string with one-cycle read latency, and writes the three hit counts back.
module pattern_scan_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int NBYTES   = pattern_scan_pkg::NBYTES,
    parameter int PAT_ADDR = pattern_scan_pkg::PAT_ADDR,
    parameter int RES_ADDR = pattern_scan_pkg::RES_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    import pattern_scan_pkg::*;

    scan_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic             we_q, we_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [7:0]       prev_q, prev_d;
    logic [7:0]       ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;

    logic [2:0] in_cnt;
    logic [3:0] x_cnt;
    logic       cross_en;
    logic       acc_en;
    logic [7:0] ctb_sum, cto_sum, cts_sum;

    assign cross_en = (state_q == DRAIN) || (addr_q > ADDR_W'(1));
    assign acc_en   = (state_q == DRAIN) || ((state_q == SCAN) && (addr_q != '0));

    pat_win_cnt u_win (
        .win    ({prev_q, mem_rdata}),
        .pat    (pat_q),
        .mode   (cross_en),
        .in_cnt (in_cnt),
        .x_cnt  (x_cnt)
    );

    // The last byte has no successor, so its in-byte windows are folded into cts at DRAIN
    assign ctb_sum = ctb_q + 8'(in_cnt);
    assign cto_sum = cto_q + 8'(in_cnt != 3'd0);
    assign cts_sum = cts_q + 8'(x_cnt) + ((state_q == DRAIN) ? 8'(in_cnt) : 8'd0);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        done_d  = done_q;
        busy_d  = busy_q;
        pat_d   = pat_q;
        prev_d  = prev_q;
        ctb_d   = ctb_q;
        cto_d   = cto_q;
        cts_d   = cts_q;
        if (acc_en) begin
            ctb_d  = ctb_sum;
            cto_d  = cto_sum;
            cts_d  = cts_sum;
            prev_d = mem_rdata;
        end
        case (state_q)
            IDLE, DONE: begin
                addr_d = '0;
                if (start) begin
                    state_d = LOAD_PAT;
                    addr_d  = ADDR_W'(PAT_ADDR);
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            LOAD_PAT: begin
                state_d = SCAN;
                addr_d  = '0;
                ctb_d   = '0;
                cto_d   = '0;
                cts_d   = '0;
                prev_d  = '0;
            end
            SCAN: begin
                if (addr_q == '0) pat_d = mem_rdata[7:3];
                if (addr_q == ADDR_W'(NBYTES - 1)) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                state_d = WR_CTB;
                addr_d  = ADDR_W'(RES_ADDR);
                we_d    = 1'b1;
                wdata_d = ctb_sum;
            end
            WR_CTB: begin
                state_d = WR_CTO;
                addr_d  = ADDR_W'(RES_ADDR + 1);
                we_d    = 1'b1;
                wdata_d = cto_q;
            end
            WR_CTO: begin
                state_d = WR_CTS;
                addr_d  = ADDR_W'(RES_ADDR + 2);
                we_d    = 1'b1;
                wdata_d = cts_q;
            end
            WR_CTS: begin
                state_d = DONE;
                addr_d  = '0;
                wdata_d = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            pat_q   <= '0;
            prev_q  <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pat_q   <= pat_d;
            prev_q  <= prev_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign mem_req   = busy_q;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a one-cycle-latency data-memory model.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done, busy, mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    logic [7:0] dm [0:255];
    logic [7:0] we_addr [0:7];
    int         we_cnt = 0;
    int         tests = 0;
    int         fails = 0;
    int         done_at;

    pattern_scan_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= dm[mem_addr];
        if (mem_we) begin
            dm[mem_addr] <= mem_wdata;
            if (we_cnt < 8) we_addr[we_cnt] = mem_addr;
            we_cnt = we_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [4:0] pat, input logic [7:0] b);
        for (int i = 0; i < 32; i++) dm[i] = b;
        dm[32] = {pat, 3'b000};
        dm[33] = 8'hEE;
        dm[34] = 8'hEE;
        dm[35] = 8'hEE;
    endtask

    // Start a run and wait for done; p1/p2 are cycles in which a stray start is raised.
    task automatic run_scan(input int p1, input int p2);
        done_at = -1;
        we_cnt  = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_done_low", {31'd0, done}, 32'd0);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_addr", {24'd0, mem_addr}, 32'd32);
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            start = (k == p1 - 1) || (k == p2 - 1);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) done_at = k;
        end
        check("done_cycle", done_at, 37);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dm[i] = 8'h00;
        mem_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        reset = 1'b1;
        @(posedge clk);

        fill(5'b00000, 8'h00);
        run_scan(-9, -9);
        check("t1_ctb", dm[33], 128);
        check("t1_cto", dm[34], 32);
        check("t1_cts", dm[35], 252);

        fill(5'b01010, 8'h55);
        run_scan(-9, -9);
        check("t2_ctb", dm[33], 64);
        check("t2_cto", dm[34], 32);
        check("t2_cts", dm[35], 126);

        fill(5'b11111, 8'h00);
        dm[0] = 8'h07;
        dm[1] = 8'hC0;
        run_scan(-9, -9);
        check("t3_ctb", dm[33], 0);
        check("t3_cto", dm[34], 0);
        check("t3_cts", dm[35], 1);

        fill(5'b11111, 8'h00);
        run_scan(-9, -9);
        check("t4_ctb", dm[33], 0);
        check("t4_cto", dm[34], 0);
        check("t4_cts", dm[35], 0);
        check("t4_we_cnt", we_cnt, 3);
        check("t4_we_a0", we_addr[0], 33);
        check("t4_we_a1", we_addr[1], 34);
        check("t4_we_a2", we_addr[2], 35);

        // Abort mid-scan: reset low during cycle 20
        fill(5'b00000, 8'h00);
        we_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k < 20; k++) begin
            @(posedge clk);
            #1;
        end
        check("t5_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_req", {31'd0, mem_req}, 32'd0);
        check("t5_addr", {24'd0, mem_addr}, 32'd0);
        reset = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        check("t5_no_we", we_cnt, 0);
        check("t5_dm33", dm[33], 8'hEE);
        check("t5_idle_done", {31'd0, done}, 32'd0);
        run_scan(-9, -9);
        check("t5_ctb", dm[33], 128);
        check("t5_cto", dm[34], 32);
        check("t5_cts", dm[35], 252);

        // Stray starts while busy, then a restart from DONE with the same data
        fill(5'b01010, 8'h55);
        run_scan(5, 30);
        check("t6_ctb", dm[33], 64);
        check("t6_cto", dm[34], 32);
        check("t6_cts", dm[35], 126);
        check("t6_we_cnt", we_cnt, 3);
        dm[33] = 8'hEE;
        dm[34] = 8'hEE;
        dm[35] = 8'hEE;
        run_scan(-9, -9);
        check("t6r_ctb", dm[33], 64);
        check("t6r_cto", dm[34], 32);
        check("t6r_cts", dm[35], 126);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
